hazard_tag_pipe: RTL

- Producer side of the hazard-control interface: carries each instruction's register tags, write-enable and Tnew from the D stage down through the E, M and W stages.
- Presents these per stage so the hazard unit can compute forwarding and stall, and consumes that unit's stall decision to insert E-stage bubbles.
- Holds no datapath values; tags and timing only.
- Also counts stall cycles for performance debug.

---
 rtl/hazard_tag_pipe_pkg.sv | 16 +
 rtl/hazard_tag_pipe_tag_stage_reg.sv | 28 ++
 rtl/hazard_tag_pipe.sv | 60 ++++++
 3 files changed

// File: rtl/hazard_tag_pipe_pkg.sv
// hazard_tag_pipe_pkg: shared tag bundle, bubble constant and Tnew saturating decrement
package hazard_tag_pipe_pkg;
  localparam int REG_W = 5;
  localparam int TNEW_W = 2;
  typedef struct packed {
    logic [REG_W-1:0]  a1;
    logic [REG_W-1:0]  a2;
    logic [REG_W-1:0]  a3;
    logic              w;
    logic [TNEW_W-1:0] tnew;
  } tag_t;
  localparam tag_t TAG_BUBBLE = '0;
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction
endpackage

// File: rtl/hazard_tag_pipe_tag_stage_reg.sv
// tag_stage_reg: one pipeline stage of hazard tags with load, bubble and Tnew-decrement controls
module tag_stage_reg
  import hazard_tag_pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic bubble_i,
  input  logic dec_i,
  input  tag_t tag_i,
  output tag_t tag_o
);
  tag_t tag_d, tag_q;
  logic wr_en;
  always_comb begin
    wr_en = tag_i.w && (tag_i.a3 != '0);
    tag_d = !load_i ? tag_q : bubble_i ? TAG_BUBBLE : '{
      a1:   tag_i.a1,
      a2:   tag_i.a2,
      a3:   wr_en ? tag_i.a3 : '0,
      w:    wr_en,
      tnew: dec_i ? sat_dec(tag_i.tnew) : tag_i.tnew
    };
  end
  always_ff @(posedge clk)
    tag_q <= reset ? TAG_BUBBLE : tag_d;
  assign tag_o = tag_q;
endmodule

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: carries register tags, write-enable and Tnew through E/M/W and counts stall cycles
module hazard_tag_pipe #(
  parameter int REG_W  = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  D_A1,
  input  logic [REG_W-1:0]  D_A2,
  input  logic [REG_W-1:0]  D_A3,
  input  logic              D_W,
  input  logic [TNEW_W-1:0] D_tnew,
  input  logic              stall,
  output logic [REG_W-1:0]  E_A1,
  output logic [REG_W-1:0]  E_A2,
  output logic [REG_W-1:0]  M_A2,
  output logic [REG_W-1:0]  A3_E,
  output logic [REG_W-1:0]  A3_M,
  output logic [REG_W-1:0]  A3_W,
  output logic [TNEW_W-1:0] tnew_e,
  output logic [TNEW_W-1:0] tnew_m,
  output logic              E_W,
  output logic              M_W,
  output logic              W_W,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hazard_tag_pipe_pkg::*;
  tag_t d_tag, e_q, m_q, w_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic unused_bits;
  assign d_tag = '{a1: D_A1, a2: D_A2, a3: D_A3, w: D_W, tnew: D_tnew};
  tag_stage_reg u_e (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(stall), .dec_i(1'b0),
    .tag_i(d_tag), .tag_o(e_q)
  );
  tag_stage_reg u_m (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(1'b0), .dec_i(1'b1),
    .tag_i(e_q), .tag_o(m_q)
  );
  tag_stage_reg u_w (
    .clk(clk), .reset(reset), .load_i(1'b1), .bubble_i(1'b0), .dec_i(1'b0),
    .tag_i(m_q), .tag_o(w_q)
  );
  always_ff @(posedge clk)
    stall_cnt_q <= reset ? '0 : (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign E_A1      = e_q.a1;
  assign E_A2      = e_q.a2;
  assign A3_E      = e_q.a3;
  assign E_W       = e_q.w;
  assign tnew_e    = e_q.tnew;
  assign M_A2      = m_q.a2;
  assign A3_M      = m_q.a3;
  assign M_W       = m_q.w;
  assign tnew_m    = m_q.tnew;
  assign A3_W      = w_q.a3;
  assign W_W       = w_q.w;
  assign stall_cnt = stall_cnt_q;
  assign unused_bits = ^{m_q.a1, w_q.a1, w_q.a2, w_q.tnew};
endmodule
